stepper_pulse_driver: RTL
=========================

# stepper_pulse_driver

- Consumer end of the controller→stepper handshake. Accepts a two-axis move command (step counts plus directions) when the controller pulses `dataReady`, and holds `stepperReady` low while the move runs.
- Drives STEP/DIR pins for two stepper drivers with programmable DIR setup, STEP high time and STEP low time.
- Both axes start together; an axis stops pulsing once its count is exhausted.
- Sits between the kinematics controller and the board's driver pins.

## Interface
- `DIR_SETUP_CYC`, default 50: clk cycles DIR is held stable before the first STEP rise (≥1).
- `STEP_HIGH_CYC`, default 100: clk cycles per STEP high phase (≥1).
- `STEP_LOW_CYC`, default 400: clk cycles per STEP low phase (≥1).
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `steps1`  in  8  axis-1 step count, unsigned.
- `steps2`  in  8  axis-2 step count, unsigned.
- `dir1`  in  1  axis-1 direction; 1 = positive.
- `dir2`  in  1  axis-2 direction; 1 = positive.
- `dataReady`  in  1  command-valid strobe.
- `stepperReady`  out  1  high when idle and able to accept a command.
- `step1_out`  out  1  axis-1 STEP pin.
- `step2_out`  out  1  axis-2 STEP pin.
- `dir1_out`  out  1  axis-1 DIR pin (registered).
- `dir2_out`  out  1  axis-2 DIR pin (registered).
- `moveDone`  out  1  one-cycle pulse when the move completes.
- `pos1`  out  16  signed accumulated axis-1 position; present only with `STEPPER_POS_TRACK_EN`.
- `pos2`  out  16  signed accumulated axis-2 position; present only with `STEPPER_POS_TRACK_EN`.

## Operation
- **Reset values:** `stepperReady`=1; `step1_out`, `step2_out`, `dir1_out`, `dir2_out`, `moveDone`=0; `pos1`, `pos2`=0; state IDLE; counters 0.
- **Accept:** a command is accepted on a rising edge where `dataReady` && `stepperReady`. The edge latches `steps1`, `steps2` into remaining counters, loads `dir1_out`/`dir2_out`, and drops `stepperReady`.
- `dataReady` while busy is ignored. There is no queue, and the strobe is not stored.
- **State machine (IDLE, SETUP, HIGH, LOW, DONE):**
  - IDLE → SETUP on accept. IDLE → DONE on accept when both counts are 0; DIR pins still update.
  - SETUP holds `DIR_SETUP_CYC` cycles → HIGH.
  - HIGH holds `STEP_HIGH_CYC` cycles. `stepN_out`=1 for every axis whose remaining count is >0 on HIGH entry.
  - HIGH → LOW: STEP pins fall, and each axis that pulsed decrements its remaining count by 1.
  - LOW holds `STEP_LOW_CYC` cycles, then → HIGH if either remaining count is >0, else → DONE.
  - DONE lasts one cycle with `moveDone`=1, then → IDLE with `stepperReady`=1.
- **Outputs:** STEP and DIR pins are registered, glitch-free outputs. DIR never changes outside IDLE→SETUP/DONE acceptance.
- **Arithmetic:** remaining counters are 8-bit unsigned and never underflow, because decrement is gated on >0. The phase timer is sized `$clog2` of the largest parameter, +1.
- **Reset mid-move:** all pins drop immediately (async), and the move is abandoned.

## Timing
- Accept at edge N: `stepperReady`=0 and DIR valid from N+1; SETUP spans N+1..N+DIR_SETUP_CYC.
- First STEP rise at N+DIR_SETUP_CYC+1.
- Pulse period = `STEP_HIGH_CYC`+`STEP_LOW_CYC`.
- `moveDone` at N+DIR_SETUP_CYC+max(steps1,steps2)·period+1.
- `stepperReady` rises one cycle after `moveDone`.
- Zero-step move: `moveDone` at N+1, `stepperReady` at N+2.
- Back-to-back: the earliest next accept is the edge on which `stepperReady` is first seen high.

## Configuration
- `STEPPER_POS_TRACK_EN` defined:
  - Ports `pos1`/`pos2` exist.
  - On each HIGH→LOW transition where axis N pulsed, `posN` += 1 if `dirN_out`, else −1.
  - 16-bit two's-complement wrap (32767+1 → −32768).
- Undefined: the ports and accumulators are absent; all other behaviour is identical.

## Structure
- **Package `stepper_pkg`:** state enum `stepper_state_t` (IDLE, SETUP, HIGH, LOW, DONE), default timing constants, and position width constant `STEPPER_POS_W`=16.
- **Sub-module `step_channel`:** one instance per axis. It holds:
  - the remaining counter,
  - the STEP/DIR registers,
  - the optional position accumulator,
  - an `active` (remaining>0) flag.
- **Top level:** the shared FSM and phase timer.

## Test plan
(DIR_SETUP_CYC=4, STEP_HIGH_CYC=2, STEP_LOW_CYC=3)
- Reset → `stepperReady`=1 and all pins 0; assert `reset` mid-HIGH → STEP pins 0 in the same cycle, and IDLE after release.
- steps1=3, steps2=1, dir1=1, dir2=0, accept at cycle 0 → STEP rises at 5, 10, 15 on axis 1 and at 5 only on axis 2; `moveDone` at 20; `stepperReady` at 21; with macro, pos1=+3, pos2=−1.
- steps1=0, steps2=0, dir1=1 → no STEP pulses; `dir1_out`=1 from 1; `moveDone` at 1; `stepperReady` at 2.
- `dataReady` pulsed at cycle 7 during a move → ignored: counts unchanged and `moveDone` timing unchanged.
- steps1=255, steps2=255 → exactly 255 pulses per axis; `moveDone` at 4+255·5+1=1280.
- With macro: pos1 preset to 32767 by prior moves, then steps1=1, dir1=1 → pos1=−32768.

Source files
------------

// File: rtl/stepper_pkg.sv
// stepper_pkg: shared types and constants for the two-axis stepper pulse driver.
//   stepper_state_t        : FSM states (IDLE, SETUP, HIGH, LOW, DONE)
//   STEPPER_DEF_*_CYC      : default DIR setup / STEP high / STEP low phase lengths
//   STEPPER_STEPS_W        : width of a per-axis step count
//   STEPPER_POS_W          : width of the optional signed position accumulators
//   stepper_max3()         : largest of three phase lengths (sizes the phase timer)
package stepper_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } stepper_state_t;

  localparam int unsigned STEPPER_DEF_DIR_SETUP_CYC = 32'd50;
  localparam int unsigned STEPPER_DEF_STEP_HIGH_CYC = 32'd100;
  localparam int unsigned STEPPER_DEF_STEP_LOW_CYC  = 32'd400;
  localparam int unsigned STEPPER_STEPS_W           = 32'd8;
  localparam int unsigned STEPPER_POS_W             = 32'd16;

  function automatic int unsigned stepper_max3(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/stepper_pulse_driver_if.sv
// stepper_pulse_driver_if: controller -> stepper command handshake.
//   steps1/steps2 : per-axis step counts (unsigned)
//   dir1/dir2     : per-axis direction, 1 = positive
//   dataReady     : command-valid strobe from the controller
//   stepperReady  : driver idle and able to take a command
// Modports: master = controller side, slave = stepper driver side.
interface stepper_pulse_driver_if;
  import stepper_pkg::*;

  logic [STEPPER_STEPS_W-1:0] steps1;
  logic [STEPPER_STEPS_W-1:0] steps2;
  logic                       dir1;
  logic                       dir2;
  logic                       dataReady;
  logic                       stepperReady;

  modport master (output steps1, steps2, dir1, dir2, dataReady, input stepperReady);
  modport slave  (input steps1, steps2, dir1, dir2, dataReady, output stepperReady);

endinterface

// File: rtl/stepper_pulse_driver_step_channel.sv
// step_channel: one stepper axis.
//   clk, reset : system clock, async active-high reset
//   load_i     : command accepted; capture steps_i / dir_i
//   rise_i     : entering a STEP high phase; pulse if steps remain
//   fall_i     : leaving a STEP high phase; retire the pulse just issued
//   step_o     : registered STEP pin
//   dir_o      : registered DIR pin
//   active_o   : remaining count > 0
//   pos_o      : signed position accumulator (only with STEPPER_POS_TRACK_EN)
module step_channel
  import stepper_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_i,
  input  logic [STEPPER_STEPS_W-1:0] steps_i,
  input  logic                       dir_i,
  input  logic                       rise_i,
  input  logic                       fall_i,
  output logic                       step_o,
  output logic                       dir_o,
  output logic                       active_o
`ifdef STEPPER_POS_TRACK_EN
  ,
  output logic signed [STEPPER_POS_W-1:0] pos_o
`endif
);

  logic [STEPPER_STEPS_W-1:0] remaining_q, remaining_d;
  logic                       step_q, step_d;
  logic                       dir_q, dir_d;
  logic                       active_s;
`ifdef STEPPER_POS_TRACK_EN
  logic signed [STEPPER_POS_W-1:0] pos_q, pos_d;
`endif

  assign active_s = (remaining_q != {STEPPER_STEPS_W{1'b0}});

  // Next-state for count, STEP/DIR pins and optional position.
  always_comb begin
    remaining_d = remaining_q;
    step_d      = step_q;
    dir_d       = dir_q;
`ifdef STEPPER_POS_TRACK_EN
    pos_d       = pos_q;
`endif
    if (load_i) begin
      remaining_d = steps_i;
      dir_d       = dir_i;
      step_d      = 1'b0;
    end else if (rise_i) begin
      step_d = active_s;
    end else if (fall_i) begin
      step_d = 1'b0;
      // Only an axis that actually pulsed consumes a step; the >0 gate keeps
      // the counter from ever wrapping below zero.
      if (step_q && active_s) begin
        remaining_d = remaining_q - STEPPER_STEPS_W'(1'b1);
`ifdef STEPPER_POS_TRACK_EN
        pos_d = dir_q ? (pos_q + 16'sd1) : (pos_q - 16'sd1);
`endif
      end else begin
        remaining_d = remaining_q;
      end
    end else begin
      step_d = step_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining_q <= {STEPPER_STEPS_W{1'b0}};
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
`ifdef STEPPER_POS_TRACK_EN
      pos_q       <= 16'sd0;
`endif
    end else begin
      remaining_q <= remaining_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
`ifdef STEPPER_POS_TRACK_EN
      pos_q       <= pos_d;
`endif
    end
  end

  assign step_o   = step_q;
  assign dir_o    = dir_q;
  assign active_o = active_s;
`ifdef STEPPER_POS_TRACK_EN
  assign pos_o    = pos_q;
`endif

endmodule

// File: rtl/stepper_pulse_driver.sv
// stepper_pulse_driver: takes a two-axis move command over the handshake
// interface and drives STEP/DIR pins for two stepper drivers.
//   clk, reset          : system clock, async active-high reset
//   cmd (slave)         : steps1/2, dir1/2, dataReady in; stepperReady out
//   step1_out/step2_out : registered STEP pins
//   dir1_out/dir2_out   : registered DIR pins
//   moveDone            : one-cycle pulse at the end of a move
//   pos1/pos2           : signed positions, only with STEPPER_POS_TRACK_EN
// Both axes share one FSM and phase timer; each axis stops pulsing once its
// own count is used up.
module stepper_pulse_driver
  import stepper_pkg::*;
#(
  parameter int unsigned DIR_SETUP_CYC = STEPPER_DEF_DIR_SETUP_CYC,
  parameter int unsigned STEP_HIGH_CYC = STEPPER_DEF_STEP_HIGH_CYC,
  parameter int unsigned STEP_LOW_CYC  = STEPPER_DEF_STEP_LOW_CYC
)(
  input  logic                    clk,
  input  logic                    reset,
  stepper_pulse_driver_if.slave   cmd,
  output logic                    step1_out,
  output logic                    step2_out,
  output logic                    dir1_out,
  output logic                    dir2_out,
  output logic                    moveDone
`ifdef STEPPER_POS_TRACK_EN
  ,
  output logic signed [STEPPER_POS_W-1:0] pos1,
  output logic signed [STEPPER_POS_W-1:0] pos2
`endif
);

  localparam int unsigned MAX_CYC = stepper_max3(DIR_SETUP_CYC, STEP_HIGH_CYC, STEP_LOW_CYC);
  localparam int unsigned TMR_W   = $clog2(MAX_CYC) + 32'd1;
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(DIR_SETUP_CYC - 32'd1);
  localparam logic [TMR_W-1:0] HIGH_LOAD  = TMR_W'(STEP_HIGH_CYC - 32'd1);
  localparam logic [TMR_W-1:0] LOW_LOAD   = TMR_W'(STEP_LOW_CYC - 32'd1);

  stepper_state_t   state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             accept_s, rise_s, fall_s;
  logic             active1_s, active2_s;
  logic             timer_zero_s;

  assign timer_zero_s = (timer_q == {TMR_W{1'b0}});

  // FSM next-state, phase timer and STEP edge strobes to the channels.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    accept_s = 1'b0;
    rise_s   = 1'b0;
    fall_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd.dataReady && ready_q) begin
          accept_s = 1'b1;
          // A zero-length move still updates DIR but skips straight to DONE.
          if ((cmd.steps1 == {STEPPER_STEPS_W{1'b0}}) && (cmd.steps2 == {STEPPER_STEPS_W{1'b0}})) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SETUP;
            timer_d = SETUP_LOAD;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      SETUP: begin
        if (timer_zero_s) begin
          state_d = HIGH;
          timer_d = HIGH_LOAD;
          rise_s  = 1'b1;
        end else begin
          timer_d = timer_q - TMR_W'(1'b1);
        end
      end
      HIGH: begin
        if (timer_zero_s) begin
          state_d = LOW;
          timer_d = LOW_LOAD;
          fall_s  = 1'b1;
        end else begin
          timer_d = timer_q - TMR_W'(1'b1);
        end
      end
      LOW: begin
        if (!timer_zero_s) begin
          timer_d = timer_q - TMR_W'(1'b1);
        end else if (active1_s || active2_s) begin
          state_d = HIGH;
          timer_d = HIGH_LOAD;
          rise_s  = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        timer_d = {TMR_W{1'b0}};
        ready_d = 1'b1;
      end
    endcase
  end

  // FSM, timer and handshake/status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= {TMR_W{1'b0}};
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign cmd.stepperReady = ready_q;
  assign moveDone         = done_q;

  step_channel u_axis1 (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept_s),
    .steps_i  (cmd.steps1),
    .dir_i    (cmd.dir1),
    .rise_i   (rise_s),
    .fall_i   (fall_s),
    .step_o   (step1_out),
    .dir_o    (dir1_out),
    .active_o (active1_s)
`ifdef STEPPER_POS_TRACK_EN
    ,
    .pos_o    (pos1)
`endif
  );

  step_channel u_axis2 (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept_s),
    .steps_i  (cmd.steps2),
    .dir_i    (cmd.dir2),
    .rise_i   (rise_s),
    .fall_i   (fall_s),
    .step_o   (step2_out),
    .dir_o    (dir2_out),
    .active_o (active2_s)
`ifdef STEPPER_POS_TRACK_EN
    ,
    .pos_o    (pos2)
`endif
  );

endmodule
